level_fifo: RTL

Parametrised synchronous FIFO, successor to the team's basic depth FIFO, used as the RX/TX buffer between the UART byte engines and the host-side logic. Adds:
- arbitrary (non-power-of-two) depth
- explicit fill-level output
- programmable almost-full/almost-empty watermarks
- synchronous flush
- sticky overflow/underflow error flags

Show-ahead (first-word-fall-through) read port.

---
 rtl/level_fifo.sv | 99 +++++++++
 1 files changed

// File: rtl/level_fifo.sv
// Show-ahead synchronous FIFO with fill level, watermarks, flush and sticky error flags.
// Ports: clk_i, rst_n_i (async active-low), flush_i; data_i/write_enable_i/full_o write side;
// data_o/read_enable_i/read_valid_o read side; level_o, almost_full_o, almost_empty_o,
// overflow_o, underflow_o status.
module level_fifo #(
  parameter int p_depth     = 32,
  parameter int p_word_size = 8,
  parameter int p_af_thresh = p_depth - 2,
  parameter int p_ae_thresh = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           flush_i,
  input  logic [p_word_size-1:0]         data_i,
  input  logic                           write_enable_i,
  output logic                           full_o,
  output logic [p_word_size-1:0]         data_o,
  input  logic                           read_enable_i,
  output logic                           read_valid_o,
  output logic [$clog2(p_depth+1)-1:0]   level_o,
  output logic                           almost_full_o,
  output logic                           almost_empty_o,
  output logic                           overflow_o,
  output logic                           underflow_o
);

  localparam int LW = $clog2(p_depth + 1);
  localparam int PW = $clog2(p_depth);

  localparam logic [LW-1:0] L_DEPTH = LW'(p_depth);
  localparam logic [LW-1:0] L_AF    = LW'(p_af_thresh);
  localparam logic [LW-1:0] L_AE    = LW'(p_ae_thresh);
  localparam logic [PW-1:0] P_LAST  = PW'(p_depth - 1);

  logic [p_word_size-1:0] r_mem [p_depth];
  logic [PW-1:0]          r_rd_ptr;
  logic [PW-1:0]          r_wr_ptr;
  logic [LW-1:0]          r_level;
  logic                   r_ovf;
  logic                   r_udf;

  logic          w_full;
  logic          w_valid;
  logic          w_wr_ok;
  logic          w_rd_ok;
  logic [PW-1:0] w_rd_nxt;
  logic [PW-1:0] w_wr_nxt;

  // Status comes only from the level register, never from the enables.
  assign w_full  = (r_level == L_DEPTH);
  assign w_valid = (r_level != '0);
  assign w_wr_ok = write_enable_i & ~w_full;
  assign w_rd_ok = read_enable_i & w_valid;

  // Explicit wrap so non-power-of-two depths work.
  assign w_rd_nxt = (r_rd_ptr == P_LAST) ? '0 : r_rd_ptr + PW'(1);
  assign w_wr_nxt = (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + PW'(1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= w_wr_nxt;
      if (w_rd_ok) r_rd_ptr <= w_rd_nxt;
      unique case ({w_wr_ok, w_rd_ok})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (write_enable_i & w_full)  r_ovf <= 1'b1;
      if (read_enable_i & ~w_valid) r_udf <= 1'b1;
    end
  end

  // Storage is not reset; contents are meaningless while level is 0.
  always_ff @(posedge clk_i) begin
    if (w_wr_ok & ~flush_i) r_mem[r_wr_ptr] <= data_i;
  end

  assign data_o         = r_mem[r_rd_ptr];
  assign full_o         = w_full;
  assign read_valid_o   = w_valid;
  assign level_o        = r_level;
  assign almost_full_o  = (r_level >= L_AF);
  assign almost_empty_o = (r_level <= L_AE);
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_udf;

endmodule
